// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, one-cycle stall and flush bubble.
// Optional stall counter enabled by defining HAZARD_STALL_COUNT_EN.
module id_ex_hazard_stage #(
  parameter int INSTR_W = 19,
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] IF_ID_instruction,
  input  logic               IF_ID_valid,
  input  logic [DATA_W-1:0]  id_reg_A,
  input  logic [DATA_W-1:0]  id_reg_B,
  input  logic [1:0]         id_alu_B_mux,
  input  logic               flush,
  output logic [INSTR_W-1:0] ID_EX_instruction,
  output logic [DATA_W-1:0]  ID_EX_reg_A,
  output logic [DATA_W-1:0]  ID_EX_reg_B,
  output logic [1:0]         ID_EX_alu_B_mux,
  output logic               ID_EX_valid,
  output logic               pc_write,
  output logic               IF_ID_write,
  output logic [CNT_W-1:0]   stall_count
);

  localparam logic [4:0] OP_LW = 5'b10000;
  localparam logic [4:0] OP_SW = 5'b10001;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0]  reg_a_q, reg_a_d;
  logic [DATA_W-1:0]  reg_b_q, reg_b_d;
  logic [1:0]         mux_q, mux_d;
  logic               valid_q, valid_d;

  logic [4:0] id_op;
  logic [2:0] id_a, id_b, ex_dst;
  logic       id_alu, id_imm, id_lw, id_sw;
  logic       id_reads_a, id_reads_b;
  logic       ex_is_lw, hazard, bubble;

  assign id_op  = IF_ID_instruction[18:14];
  assign id_a   = IF_ID_instruction[10:8];
  assign id_b   = IF_ID_instruction[7:5];
  assign ex_dst = instr_q[13:11];

  assign id_alu     = ~id_op[4];
  assign id_imm     = id_op[3];
  assign id_lw      = (id_op == OP_LW);
  assign id_sw      = (id_op == OP_SW);
  assign id_reads_a = id_alu | id_lw | id_sw;
  assign id_reads_b = id_alu & ~id_imm;
  assign ex_is_lw   = (instr_q[18:14] == OP_LW);

  // The SW data register (dst field) is deliberately absent: MEM forwarding covers it.
  assign hazard = valid_q & ex_is_lw & (ex_dst != 3'd0) & IF_ID_valid &
                  ((id_reads_a & (id_a == ex_dst)) | (id_reads_b & (id_b == ex_dst)));

  always_comb begin
    state_d     = state_q;
    bubble      = 1'b0;
    pc_write    = 1'b1;
    IF_ID_write = 1'b1;
    if (flush) begin
      bubble  = 1'b1;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard) begin
            bubble      = 1'b1;
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            state_d     = STALL;
          end
        end
        STALL:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    instr_d = IF_ID_instruction;
    reg_a_d = id_reg_A;
    reg_b_d = id_reg_B;
    mux_d   = id_alu_B_mux;
    valid_d = IF_ID_valid;
    if (bubble) begin
      instr_d = '0;
      reg_a_d = '0;
      reg_b_d = '0;
      mux_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      instr_q <= '0;
      reg_a_q <= '0;
      reg_b_q <= '0;
      mux_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      mux_q   <= mux_d;
      valid_q <= valid_d;
    end
  end

  assign ID_EX_instruction = instr_q;
  assign ID_EX_reg_A       = reg_a_q;
  assign ID_EX_reg_B       = reg_b_q;
  assign ID_EX_alu_B_mux   = mux_q;
  assign ID_EX_valid       = valid_q;

`ifdef HAZARD_STALL_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at all-ones so a long run never wraps back to a small count.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == RUN) && (state_d == STALL) && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stall_count = cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Randomized + directed bench for id_ex_hazard_stage against a rule-level reference model.
module tb_id_ex_hazard_stage;
  localparam int IW = 19;
  localparam int DW = 16;
  localparam int CW = 2;
  localparam int CNT_MAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] IF_ID_instruction;
  logic          IF_ID_valid;
  logic [DW-1:0] id_reg_A, id_reg_B;
  logic [1:0]    id_alu_B_mux;
  logic          flush;
  logic [IW-1:0] ID_EX_instruction;
  logic [DW-1:0] ID_EX_reg_A, ID_EX_reg_B;
  logic [1:0]    ID_EX_alu_B_mux;
  logic          ID_EX_valid, pc_write, IF_ID_write;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  id_ex_hazard_stage #(.INSTR_W(IW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_instruction(IF_ID_instruction), .IF_ID_valid(IF_ID_valid),
    .id_reg_A(id_reg_A), .id_reg_B(id_reg_B), .id_alu_B_mux(id_alu_B_mux),
    .flush(flush),
    .ID_EX_instruction(ID_EX_instruction), .ID_EX_reg_A(ID_EX_reg_A),
    .ID_EX_reg_B(ID_EX_reg_B), .ID_EX_alu_B_mux(ID_EX_alu_B_mux),
    .ID_EX_valid(ID_EX_valid), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
    .stall_count(stall_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: what EX should hold, whether the previous cycle was a stall, and stalls taken.
  logic [IW-1:0] m_instr;
  logic [DW-1:0] m_a, m_b;
  logic [1:0]    m_mux;
  logic          m_valid;
  bit            m_held;
  int            m_cnt;
  bit            last_pcw;

  function automatic logic [IW-1:0] mk(input logic [4:0] op, input logic [2:0] d, a, b);
    return {op, d, a, b, 5'b00000};
  endfunction

  function automatic bit uses_reg(input logic [IW-1:0] ins, input logic [2:0] r);
    logic [4:0] op;
    bit alu, imm, mem;
    op  = ins[18:14];
    alu = (op < 5'd16);
    imm = (op >= 5'd8) && alu;
    mem = (op == 5'd16) || (op == 5'd17);
    return ((alu || mem) && ins[10:8] == r) || (alu && !imm && ins[7:5] == r);
  endfunction

  function automatic int exp_cnt();
`ifdef HAZARD_STALL_COUNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_clear();
    m_instr = '0; m_a = '0; m_b = '0; m_mux = '0; m_valid = 1'b0;
    m_held = 0; m_cnt = 0;
  endtask

  task automatic check_ex();
    check("ex_instr", 32'(ID_EX_instruction), 32'(m_instr));
    check("ex_reg_a", 32'(ID_EX_reg_A), 32'(m_a));
    check("ex_reg_b", 32'(ID_EX_reg_B), 32'(m_b));
    check("ex_mux", 32'(ID_EX_alu_B_mux), 32'(m_mux));
    check("ex_valid", 32'(ID_EX_valid), 32'(m_valid));
    check("stall_count", 32'(stall_count), 32'(exp_cnt()));
  endtask

  // Entered just after a falling edge; leaves just after the next falling edge.
  task automatic step(input logic [IW-1:0] ins, input logic v, input logic [DW-1:0] a, b,
                      input logic [1:0] mx, input logic fl);
    bit stall;
    IF_ID_instruction = ins; IF_ID_valid = v; id_reg_A = a; id_reg_B = b;
    id_alu_B_mux = mx; flush = fl;
    #1;
    stall = !m_held && m_valid && (m_instr[18:14] == 5'd16) && (m_instr[13:11] != 3'd0) &&
            v && uses_reg(ins, m_instr[13:11]) && !fl;
    last_pcw = !stall;
    check("pc_write", 32'(pc_write), 32'(!stall));
    check("if_id_write", 32'(IF_ID_write), 32'(!stall));
    if (fl || stall) begin
      m_instr = '0; m_a = '0; m_b = '0; m_mux = '0; m_valid = 1'b0;
      m_held = stall;
      if (stall && m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_instr = ins; m_a = a; m_b = b; m_mux = mx; m_valid = v;
      m_held = 0;
    end
    @(negedge clk);
    check_ex();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_ex();
    check("rst_pc_write", 32'(pc_write), 32'd1);
    @(negedge clk);
    check("rst_hold_valid", 32'(ID_EX_valid), 32'd0);
    rst = 1'b0;
  endtask

  logic [IW-1:0] r_ins;
  logic          r_v, r_fl;
  logic [DW-1:0] r_a, r_b;
  logic [1:0]    r_mx;

  task automatic rand_instr();
    logic [2:0] d, a, b;
    d = 3'($urandom_range(0, 3));
    a = 3'($urandom_range(0, 3));
    b = 3'($urandom_range(0, 3));
    case ($urandom_range(0, 5))
      0: r_ins = mk(5'b10000, d, a, b);
      1: r_ins = mk(5'b10001, d, a, b);
      2: r_ins = mk({2'b00, 3'($urandom)}, d, a, b);
      3: r_ins = mk({2'b01, 3'($urandom)}, d, a, b);
      4: r_ins = mk({1'b1, 4'($urandom)}, d, a, b);
      default: r_ins = '0;
    endcase
    r_ins[4:0] = 5'($urandom);
    r_v  = ($urandom_range(0, 9) != 0);
    r_a  = 16'($urandom);
    r_b  = 16'($urandom);
    r_mx = 2'($urandom);
  endtask

  localparam logic [4:0] LW = 5'b10000, SW = 5'b10001, ADD = 5'b00000, ADDI = 5'b01000;

  initial begin
    rst = 1'b1;
    IF_ID_instruction = '0; IF_ID_valid = 1'b0; id_reg_A = '0; id_reg_B = '0;
    id_alu_B_mux = '0; flush = 1'b0;
    model_clear();
    last_pcw = 1;
    repeat (2) @(negedge clk);
    check_ex();
    check("reset_pc_write", 32'(pc_write), 32'd1);
    rst = 1'b0;

    // Load-use: stall one cycle, bubble, then the ADD.
    step(mk(LW, 3'd2, 3'd1, 3'd0), 1, 16'h1111, 16'h2222, 2'd1, 0);
    step(mk(ADD, 3'd3, 3'd2, 3'd1), 1, 16'h3333, 16'h4444, 2'd0, 0);
    check("t2_stall", 32'(last_pcw), 32'd0);
    check("t2_bubble", 32'(ID_EX_valid), 32'd0);
    step(mk(ADD, 3'd3, 3'd2, 3'd1), 1, 16'h3333, 16'h4444, 2'd0, 0);
    check("t2_add_in_ex", 32'(ID_EX_instruction), 32'(mk(ADD, 3'd3, 3'd2, 3'd1)));
    check("t2_add_valid", 32'(ID_EX_valid), 32'd1);

    // Immediate B, SW data register: no stall; SW base: stall.
    step(mk(LW, 3'd2, 3'd1, 3'd0), 1, 16'h0, 16'h0, 2'd0, 0);
    step(mk(ADDI, 3'd3, 3'd1, 3'd2), 1, 16'h5, 16'h6, 2'd2, 0);
    check("t3_addi_nostall", 32'(last_pcw), 32'd1);
    step(mk(LW, 3'd2, 3'd1, 3'd0), 1, 16'h0, 16'h0, 2'd0, 0);
    step(mk(SW, 3'd2, 3'd1, 3'd0), 1, 16'h7, 16'h8, 2'd1, 0);
    check("t3_swdata_nostall", 32'(last_pcw), 32'd1);
    step(mk(LW, 3'd2, 3'd1, 3'd0), 1, 16'h0, 16'h0, 2'd0, 0);
    step(mk(SW, 3'd4, 3'd2, 3'd0), 1, 16'h7, 16'h8, 2'd1, 0);
    check("t3_swbase_stall", 32'(last_pcw), 32'd0);
    step(mk(SW, 3'd4, 3'd2, 3'd0), 1, 16'h7, 16'h8, 2'd1, 0);

    // LW to r0 never stalls.
    step(mk(LW, 3'd0, 3'd1, 3'd0), 1, 16'h0, 16'h0, 2'd0, 0);
    step(mk(ADD, 3'd3, 3'd0, 3'd0), 1, 16'h9, 16'hA, 2'd0, 0);
    check("t4_r0_nostall", 32'(last_pcw), 32'd1);

    // Hazard with flush in the same cycle.
    step(mk(LW, 3'd2, 3'd1, 3'd0), 1, 16'h0, 16'h0, 2'd0, 0);
    step(mk(ADD, 3'd3, 3'd2, 3'd2), 1, 16'hB, 16'hC, 2'd3, 1);
    check("t5_flush_pc", 32'(last_pcw), 32'd1);
    check("t5_flush_bubble", 32'(ID_EX_valid), 32'd0);

    // Reset while a stall is being requested.
    step(mk(LW, 3'd2, 3'd1, 3'd0), 1, 16'h0, 16'h0, 2'd0, 0);
    IF_ID_instruction = mk(ADD, 3'd3, 3'd2, 3'd1); IF_ID_valid = 1'b1; flush = 1'b0;
    #1;
    check("t1_pre_reset_stall", 32'(pc_write), 32'd0);
    do_reset();
    step(mk(ADD, 3'd3, 3'd2, 3'd1), 1, 16'h3, 16'h4, 2'd0, 0);
    check("t1_run_after_reset", 32'(last_pcw), 32'd1);

    // Five stalls: counter saturates.
    for (int k = 0; k < 5; k++) begin
      step(mk(LW, 3'd1, 3'd0, 3'd0), 1, 16'h0, 16'h0, 2'd0, 0);
      step(mk(ADD, 3'd2, 3'd1, 3'd0), 1, 16'h0, 16'h0, 2'd0, 0);
      step(mk(ADD, 3'd2, 3'd1, 3'd0), 1, 16'h0, 16'h0, 2'd0, 0);
    end
`ifdef HAZARD_STALL_COUNT_EN
    check("t6_saturate", 32'(stall_count), 32'd3);
`else
    check("t6_tied_zero", 32'(stall_count), 32'd0);
`endif

    // Random traffic; ID inputs are held while the stage requests a stall.
    for (int i = 0; i < 800; i++) begin
      if (i % 250 == 125) do_reset();
      if (last_pcw) rand_instr();
      r_fl = ($urandom_range(0, 11) == 0);
      step(r_ins, r_v, r_a, r_b, r_mx, r_fl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
